// File: rtl/hazard_unit.sv
// hazard_unit: pipeline forwarding, load-use stall and two-cycle branch flush control.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic [4:0]  RsE,
  input  logic [4:0]  RtE,
  input  logic [5:0]  OPE,
  input  logic [4:0]  WriteRegE,
  input  logic [4:0]  WriteRegM,
  input  logic [4:0]  WriteRegW,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        tontbE,
  output logic        stalF,
  output logic        stalD,
  output logic        flushE,
  output logic [1:0]  forwardAE,
  output logic [1:0]  forwardBE,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);
  typedef enum logic {RUN, BR_SHADOW} state_t;
  state_t state;
  logic lwStall, inRun;
  logic [4:0] unusedWriteRegE;
  assign unusedWriteRegE = WriteRegE;
  function automatic logic [1:0] fwdSel(input logic [4:0] src);
    return (RegWriteM && WriteRegM != 5'd0 && WriteRegM == src) ? 2'b10 :
           (RegWriteW && WriteRegW != 5'd0 && WriteRegW == src) ? 2'b01 : 2'b00;
  endfunction
  assign lwStall = OPE == 6'b100011 && RegWriteE && RtE != 5'd0 && (RtE == RsD || RtE == RtD);
  assign inRun = state == RUN;
  always_comb begin
    stalF = !reset && inRun && !tontbE && lwStall;
    stalD = stalF;
    flushE = !reset && (!inRun || tontbE || lwStall);
    forwardAE = reset ? 2'b00 : fwdSel(RsE);
    forwardBE = reset ? 2'b00 : fwdSel(RtE);
  end
  // A taken branch in RUN leaves one more wrong-path instruction to kill next cycle.
  always_ff @(posedge clk)
    if (reset) state <= RUN;
    else state <= (inRun && tontbE) ? BR_SHADOW : RUN;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stallCnt, flushCnt;
  always_ff @(posedge clk)
    if (reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stalD && stallCnt != 16'hFFFF) stallCnt <= stallCnt + 16'd1;
      if (flushE && flushCnt != 16'hFFFF) flushCnt <= flushCnt + 16'd1;
    end
  assign stall_cnt = stallCnt;
  assign flush_cnt = flushCnt;
`else
  assign stall_cnt = 16'd0;
  assign flush_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed scoreboard bench for hazard_unit.
module tb_hazard_unit;
  logic clk = 0, reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic [5:0] OPE;
  logic RegWriteE, RegWriteM, RegWriteW, tontbE;
  logic stalF, stalD, flushE;
  logic [1:0] forwardAE, forwardBE;
  logic [15:0] stall_cnt, flush_cnt;
  int checks = 0, errors = 0;
  int mStall = 0, mFlush = 0;
  bit cntKnown = 0;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit cntEn = 1;
`else
  localparam bit cntEn = 0;
`endif
  typedef struct {
    string tag;
    logic sf, sd, fe;
    logic [1:0] fa, fb;
    logic rst;
  } exp_t;
  exp_t sb[$];

  hazard_unit dut (
    .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE), .OPE(OPE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .tontbE(tontbE),
    .stalF(stalF), .stalD(stalD), .flushE(flushE), .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s %s got %h expected %h", tag, name, got, want);
    end
  endtask

  task automatic quiet();
    reset = 0; RsD = 0; RtD = 0; RsE = 0; RtE = 0; OPE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; tontbE = 0;
  endtask

  task automatic loadUse(input logic [4:0] rt, input logic [4:0] rs, input logic [4:0] rtd);
    OPE = 6'b100011; RegWriteE = 1; RtE = rt; RsD = rs; RtD = rtd;
  endtask

  // One cycle: expectation queued with the stimulus, compared at the following negedge.
  task automatic step(input string tag, input logic sf, input logic sd, input logic fe,
                      input logic [1:0] fa, input logic [1:0] fb);
    exp_t e, p;
    e.tag = tag; e.sf = sf; e.sd = sd; e.fe = fe; e.fa = fa; e.fb = fb; e.rst = reset;
    sb.push_back(e);
    @(negedge clk);
    p = sb.pop_front();
    chk(p.tag, "stalF", {15'd0, stalF}, {15'd0, p.sf});
    chk(p.tag, "stalD", {15'd0, stalD}, {15'd0, p.sd});
    chk(p.tag, "flushE", {15'd0, flushE}, {15'd0, p.fe});
    chk(p.tag, "forwardAE", {14'd0, forwardAE}, {14'd0, p.fa});
    chk(p.tag, "forwardBE", {14'd0, forwardBE}, {14'd0, p.fb});
    if (cntKnown) begin
      chk(p.tag, "stall_cnt", stall_cnt, cntEn ? mStall[15:0] : 16'd0);
      chk(p.tag, "flush_cnt", flush_cnt, cntEn ? mFlush[15:0] : 16'd0);
    end
    if (p.rst) begin
      mStall = 0; mFlush = 0; cntKnown = 1;
    end else begin
      if (p.sd && mStall < 65535) mStall++;
      if (p.fe && mFlush < 65535) mFlush++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    quiet();
    @(posedge clk); #1;
    reset = 1; loadUse(5, 5, 0); tontbE = 1;
    RegWriteM = 1; WriteRegM = 5; RsE = 5; RegWriteW = 1; WriteRegW = 5;
    step("rstHot0", 0, 0, 0, 2'b00, 2'b00);
    step("rstHot1", 0, 0, 0, 2'b00, 2'b00);
    quiet();
    step("postRst", 0, 0, 0, 2'b00, 2'b00);
    loadUse(5, 5, 0);
    step("lwRsD", 1, 1, 1, 2'b00, 2'b00);
    quiet();
    step("lwDone", 0, 0, 0, 2'b00, 2'b00);
    loadUse(7, 1, 7);
    step("lwRtD", 1, 1, 1, 2'b00, 2'b00);
    loadUse(0, 0, 0);
    step("lwZero", 0, 0, 0, 2'b00, 2'b00);
    loadUse(5, 5, 0); RegWriteE = 0;
    step("lwNoWr", 0, 0, 0, 2'b00, 2'b00);
    loadUse(5, 5, 0); OPE = 6'b101011;
    step("notLw", 0, 0, 0, 2'b00, 2'b00);
    quiet();
    RegWriteM = 1; WriteRegM = 3; RegWriteW = 1; WriteRegW = 3; RsE = 3; RtE = 3;
    step("fwdM", 0, 0, 0, 2'b10, 2'b10);
    RegWriteM = 0;
    step("fwdW", 0, 0, 0, 2'b01, 2'b01);
    RegWriteM = 1; WriteRegM = 0; WriteRegW = 0; RsE = 0; RtE = 0;
    step("fwdR0", 0, 0, 0, 2'b00, 2'b00);
    WriteRegM = 3; RsE = 3; WriteRegW = 4; RtE = 4;
    step("fwdMix", 0, 0, 0, 2'b10, 2'b01);
    quiet();
    tontbE = 1;
    step("br0", 0, 0, 1, 2'b00, 2'b00);
    tontbE = 0;
    step("br1", 0, 0, 1, 2'b00, 2'b00);
    step("br2", 0, 0, 0, 2'b00, 2'b00);
    tontbE = 1; loadUse(5, 5, 0);
    step("brLw0", 0, 0, 1, 2'b00, 2'b00);
    tontbE = 0;
    step("brLw1", 0, 0, 1, 2'b00, 2'b00);
    step("brLw2", 1, 1, 1, 2'b00, 2'b00);
    quiet();
    tontbE = 1;
    step("brBr0", 0, 0, 1, 2'b00, 2'b00);
    step("brBr1", 0, 0, 1, 2'b00, 2'b00);
    tontbE = 0;
    step("brBr2", 0, 0, 0, 2'b00, 2'b00);
    tontbE = 1;
    step("brRst0", 0, 0, 1, 2'b00, 2'b00);
    reset = 1; tontbE = 0; loadUse(5, 5, 0); RegWriteM = 1; WriteRegM = 5; RsE = 5;
    step("brRst1", 0, 0, 0, 2'b00, 2'b00);
    quiet();
    step("brRst2", 0, 0, 0, 2'b00, 2'b00);
    loadUse(9, 9, 0);
    step("holdLw", 1, 1, 1, 2'b00, 2'b00);
    repeat (70000) @(posedge clk);
    mStall = (mStall + 70000 > 65535) ? 65535 : mStall + 70000;
    mFlush = (mFlush + 70000 > 65535) ? 65535 : mFlush + 70000;
    #1;
    step("holdSat", 1, 1, 1, 2'b00, 2'b00);
    quiet();
    step("final", 0, 0, 0, 2'b00, 2'b00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have inputs RsD, RtD  input  5 each  source register fields of the decode-stage instruction.
REQ-004 SHALL have inputs RsE, RtE  input  5 each  source register fields of the execute-stage instruction.
REQ-005 SHALL have input OPE  input  6  execute-stage opcode; 6'b100011 (lw) marks a load.
REQ-006 SHALL have inputs WriteRegE, WriteRegM, WriteRegW  input  5 each, and RegWriteE, RegWriteM, RegWriteW  input  1 each  destination and write-enable per stage.
REQ-007 SHALL have input tontbE  input  1  branch taken, resolved in execute this cycle.
REQ-008 SHALL have outputs stalF, stalD, flushE  output  1 each  fetch stall, decode stall, execute bubble insert.
REQ-009 SHALL have outputs forwardAE, forwardBE  output  2 each  operand select: 00 register file, 01 ResultW, 10 ALUOutM.
REQ-010 SHALL have outputs stall_cnt, flush_cnt  output  16 each  performance counters (REQ-027).

Function
REQ-011 forwardAE SHALL be 10 when RegWriteM & WriteRegM!=0 & WriteRegM==RsE; else 01 when RegWriteW & WriteRegW!=0 & WriteRegW==RsE; else 00.
REQ-012 forwardBE SHALL follow REQ-011 with RtE in place of RsE; M-stage match SHALL take priority over W-stage match.
REQ-013 Forward selects SHALL be combinational, valid in the same cycle as their inputs, and never 11.
REQ-014 lwstall SHALL be OPE==6'b100011 & RegWriteE & RtE!=0 & (RtE==RsD | RtE==RtD).
REQ-015 FSM SHALL have states RUN, BR_SHADOW; only sequential elements are state and counters.
REQ-016 In RUN with tontbE=1: flushE=1, stalF=stalD=0; next state BR_SHADOW.
REQ-017 In RUN with tontbE=0 and lwstall=1: stalF=stalD=flushE=1, for exactly one cycle per matching load; state stays RUN.
REQ-018 In RUN with neither: all stall/flush outputs 0; state stays RUN.
REQ-019 In BR_SHADOW: flushE=1, stalF=stalD=0 unconditionally (kills second wrong-path instruction); next state RUN.
REQ-020 lwstall SHALL be ignored in BR_SHADOW and in any cycle with tontbE=1 (wrong-path instruction, no stall).
REQ-021 tontbE=1 in BR_SHADOW SHALL be ignored (execute holds a bubble; cannot occur legally); next state RUN.
REQ-022 Total branch-taken penalty SHALL be exactly 2 flushed cycles; load-use penalty exactly 1 stall cycle.

Reset
REQ-023 While reset=1, stalF, stalD, flushE SHALL be 0 and forwardAE, forwardBE SHALL be 00 regardless of inputs.
REQ-024 At rising clk with reset=1, state SHALL go to RUN and stall_cnt, flush_cnt SHALL clear to 0.
REQ-025 Reset asserted in BR_SHADOW SHALL abandon the pending shadow flush; first post-reset cycle is RUN.
REQ-026 First cycle after reset deasserts SHALL evaluate hazards normally, with no residual state.

Configuration
REQ-027 Macro HAZARD_PERF_CNT_EN defined: stall_cnt increments on each clk with stalD=1; flush_cnt increments on each clk with flushE=1; both saturate at 16'hFFFF, no wrap.
REQ-028 HAZARD_PERF_CNT_EN undefined: stall_cnt, flush_cnt tied to 0, counter registers absent; all other behaviour identical.

Verification
REQ-029 OPE=100011, RegWriteE=1, RtE=5, RsD=5 for 1 cycle -> stalF=stalD=flushE=1 that cycle only; stall_cnt=1 if enabled.
REQ-030 RegWriteM=1, WriteRegM=3, RegWriteW=1, WriteRegW=3, RsE=3, RtE=3 -> forwardAE=forwardBE=10; then RegWriteM=0 -> both 01; WriteRegM=WriteRegW=0 with RsE=0 -> 00.
REQ-031 tontbE=1 one cycle -> flushE=1 that cycle and the next, stalls 0; flush_cnt=2 if enabled.
REQ-032 tontbE=1, then next cycle lwstall condition true -> no stall in either cycle, flushE=1 both cycles, third cycle RUN.
REQ-033 tontbE=1 then reset=1 next cycle -> outputs 0 during reset; after release flushE=0 with quiet inputs; counters 0.
REQ-034 (enabled) hold lwstall true for 70000 cycles -> stall_cnt stops at 16'hFFFF.
